// File: rtl/fp_mul_seq_pkg.sv
// rtl/fp_mul_seq_pkg.sv - shared types and constants for the sequential fp multiplier
package fp_mul_seq_pkg;

  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;
  localparam int BIAS          = 127;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [FRACTION_BITS-1:0] fraction;
  } float_t;

  localparam float_t CANON_NAN = 32'h7FC0_0000;
  localparam float_t POS_INF   = 32'h7F80_0000;
  localparam float_t NEG_INF   = 32'hFF80_0000;
  localparam float_t POS_ZERO  = 32'h0000_0000;
  localparam float_t NEG_ZERO  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    MULT,
    NORM,
    ROUND,
    DONE
  } state_t;

  function automatic float_t signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  function automatic float_t signed_zero(input logic s);
    return s ? NEG_ZERO : POS_ZERO;
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// rtl/fp_mul_seq_if.sv - operand/result handshake bundle for fp_mul_seq
interface fp_mul_seq_if;
  import fp_mul_seq_pkg::*;

  logic   in_valid;
  logic   in_ready;
  float_t a;
  float_t b;
  logic   out_valid;
  logic   out_ready;
  float_t result;
  logic   busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/fp_mant_mul_serial.sv
// rtl/fp_mant_mul_serial.sv - 24x24 shift-add significand multiplier, one bit per cycle
module fp_mant_mul_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        done,
  output logic [47:0] product
);

  logic [47:0] acc;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [4:0]  cnt;
  logic        running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {24'b0, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd23) running <= 1'b0;
    end
  end

  // done marks the final accumulate cycle; product is complete on the following cycle
  assign done    = running && (cnt == 5'd23);
  assign product = acc;

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - multi-cycle IEEE-754 single multiplier, flush-to-zero, RNE rounding
module fp_mul_seq
  import fp_mul_seq_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fp_mul_seq_if.slave bus
);

  state_t            state;
  float_t            ra, rb, res;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mant_q;
  logic              g_q, r_q, s_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic              mul_start, mul_done;
  logic [47:0]       product;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic res_nan, res_inf, res_zero, special;

  always_comb begin
    a_zero   = (ra.exponent == '0);
    b_zero   = (rb.exponent == '0);
    a_inf    = (ra.exponent == '1) && (ra.fraction == '0);
    b_inf    = (rb.exponent == '1) && (rb.fraction == '0);
    a_nan    = (ra.exponent == '1) && (ra.fraction != '0);
    b_nan    = (rb.exponent == '1) && (rb.fraction != '0);
    res_nan  = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
    res_inf  = !res_nan && (a_inf || b_inf);
    res_zero = !res_nan && !res_inf && (a_zero || b_zero);
    special  = res_nan || res_inf || res_zero;
  end

  assign mul_start = (state == CLASSIFY) && !special;

  fp_mant_mul_serial u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       ({1'b1, ra.fraction}),
    .b       ({1'b1, rb.fraction}),
    .done    (mul_done),
    .product (product)
  );

  logic              round_up;
  logic [24:0]       mant_rnd;
  logic [22:0]       frac_fin;
  logic signed [9:0] exp_fin;

  // a carry out of the rounded mantissa leaves 1.000..0, so only the exponent moves
  always_comb begin
    round_up = g_q && (r_q || s_q || mant_q[0]);
    mant_rnd = {1'b0, mant_q} + {24'b0, round_up};
    if (mant_rnd[24]) begin
      frac_fin = mant_rnd[23:1];
      exp_fin  = exp_q + 10'sd1;
    end else begin
      frac_fin = mant_rnd[22:0];
      exp_fin  = exp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ra          <= '0;
      rb          <= '0;
      res         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ra         <= bus.a;
          rb         <= bus.b;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state      <= CLASSIFY;
        end
        CLASSIFY: begin
          sign_q <= ra.sign ^ rb.sign;
          exp_q  <= 10'({2'b00, ra.exponent}) + 10'({2'b00, rb.exponent}) - 10'(BIAS);
          if (special) begin
            if (res_nan)      res <= CANON_NAN;
            else if (res_inf) res <= signed_inf(ra.sign ^ rb.sign);
            else              res <= signed_zero(ra.sign ^ rb.sign);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= MULT;
          end
        end
        MULT: if (mul_done) state <= NORM;
        NORM: begin
          if (product[47]) begin
            mant_q <= product[47:24];
            g_q    <= product[23];
            r_q    <= product[22];
            s_q    <= |product[21:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= product[46:23];
            g_q    <= product[22];
            r_q    <= product[21];
            s_q    <= |product[20:0];
          end
          state <= ROUND;
        end
        ROUND: begin
          if (exp_fin >= 10'sd255)   res <= signed_inf(sign_q);
          else if (exp_fin <= 10'sd0) res <= signed_zero(sign_q);
          else                        res <= {sign_q, exp_fin[7:0], frac_fin};
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = res;

endmodule
